// File: rtl/vector_division_tdm.sv
// Signed fixed-point vector divider: NUM_LANES restoring dividers time-shared over VEC_LEN
// numerators against one shared denominator, with divide-by-zero flag and saturation.
`timescale 1ns / 1ps

module vector_division_tdm #(
    parameter int unsigned VEC_LEN    = 64,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAC_BITS  = 8,
    parameter int unsigned NUM_LANES  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          vld_in,
    output logic                          rdy_out,
    input  logic [DATA_WIDTH-1:0]         den_in,
    input  logic [VEC_LEN*DATA_WIDTH-1:0] num_in,
    output logic                          vld_out,
    input  logic                          rdy_in,
    output logic [VEC_LEN*DATA_WIDTH-1:0] quo_out,
    output logic                          div_zero_out
);

    localparam int unsigned PASSES = VEC_LEN / NUM_LANES;
    localparam int unsigned ITER   = DATA_WIDTH + FRAC_BITS;
    localparam int unsigned DW     = ITER;
    localparam int unsigned IterW  = $clog2(ITER);
    localparam int unsigned PassW  = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int unsigned IdxW   = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    localparam logic [IterW-1:0]      LastIter = IterW'(ITER - 1);
    localparam logic [PassW-1:0]      LastPass = PassW'(PASSES - 1);
    localparam logic [DW-1:0]         NegLim   = DW'(1) << (DATA_WIDTH - 1);
    localparam logic [DW-1:0]         PosLim   = NegLim - DW'(1);
    localparam logic [DATA_WIDTH-1:0] SatPos   = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SatNeg   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StDivide, StDone} state_e;

    state_e                  state_q;
    logic                    vld_out_q;
    logic                    div_zero_q;
    logic                    den_neg_q;
    logic [DATA_WIDTH-1:0]   den_mag_q;
    logic [PassW-1:0]        pass_cnt_q;
    logic [IterW-1:0]        iter_cnt_q;
    logic [DATA_WIDTH-1:0]   num_q [VEC_LEN];
    logic [DATA_WIDTH-1:0]   quo_q [VEC_LEN];
    logic [DATA_WIDTH-1:0]   rem_q [NUM_LANES];
    logic [DW-1:0]           dvd_q [NUM_LANES];

    logic [DATA_WIDTH-1:0]   rem_d    [NUM_LANES];
    logic [DW-1:0]           dvd_d    [NUM_LANES];
    logic [DATA_WIDTH:0]     rem_sh   [NUM_LANES];
    logic [DATA_WIDTH:0]     diff     [NUM_LANES];
    logic [IdxW-1:0]         elem_idx [NUM_LANES];
    logic [IdxW-1:0]         next_idx [NUM_LANES];
    logic [DATA_WIDTH-1:0]   lane_num [NUM_LANES];
    logic [DATA_WIDTH-1:0]   next_num [NUM_LANES];
    logic [DATA_WIDTH-1:0]   lane_res [NUM_LANES];
    logic                    lane_neg [NUM_LANES];

    function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] x);
        return x[DATA_WIDTH-1] ? -x : x;
    endfunction

    // One restoring step per lane; the dividend register doubles as the quotient register.
    always_comb begin
        for (int l = 0; l < int'(NUM_LANES); l++) begin
            rem_sh[l] = {rem_q[l], dvd_q[l][DW-1]};
            diff[l]   = rem_sh[l] - {1'b0, den_mag_q};
            if (!diff[l][DATA_WIDTH]) begin
                rem_d[l] = diff[l][DATA_WIDTH-1:0];
                dvd_d[l] = {dvd_q[l][DW-2:0], 1'b1};
            end else begin
                rem_d[l] = rem_sh[l][DATA_WIDTH-1:0];
                dvd_d[l] = {dvd_q[l][DW-2:0], 1'b0};
            end

            elem_idx[l] = IdxW'(pass_cnt_q) * IdxW'(NUM_LANES) + IdxW'(l);
            next_idx[l] = (IdxW'(pass_cnt_q) + IdxW'(1)) * IdxW'(NUM_LANES) + IdxW'(l);
            lane_num[l] = num_q[elem_idx[l]];
            next_num[l] = (pass_cnt_q != LastPass) ? num_q[next_idx[l]] : '0;
            lane_neg[l] = lane_num[l][DATA_WIDTH-1] ^ den_neg_q;

            // A zero numerator must win over the all-ones quotient a zero divisor produces.
            if (lane_num[l] == '0) begin
                lane_res[l] = '0;
            end else if (!lane_neg[l]) begin
                lane_res[l] = (dvd_d[l] > PosLim) ? SatPos : dvd_d[l][DATA_WIDTH-1:0];
            end else begin
                lane_res[l] = (dvd_d[l] >= NegLim) ? SatNeg : -dvd_d[l][DATA_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            vld_out_q  <= 1'b0;
            div_zero_q <= 1'b0;
            den_neg_q  <= 1'b0;
            den_mag_q  <= '0;
            pass_cnt_q <= '0;
            iter_cnt_q <= '0;
            for (int i = 0; i < int'(VEC_LEN); i++) begin
                num_q[i] <= '0;
                quo_q[i] <= '0;
            end
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                rem_q[l] <= '0;
                dvd_q[l] <= '0;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (vld_in) begin
                        den_mag_q  <= abs_val(den_in);
                        den_neg_q  <= den_in[DATA_WIDTH-1];
                        div_zero_q <= (den_in == '0);
                        pass_cnt_q <= '0;
                        iter_cnt_q <= '0;
                        for (int i = 0; i < int'(VEC_LEN); i++) begin
                            num_q[i] <= num_in[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        for (int l = 0; l < int'(NUM_LANES); l++) begin
                            rem_q[l] <= '0;
                            dvd_q[l] <= DW'(abs_val(num_in[l*DATA_WIDTH +: DATA_WIDTH]))
                                        << FRAC_BITS;
                        end
                        state_q <= StDivide;
                    end
                end
                StDivide: begin
                    for (int l = 0; l < int'(NUM_LANES); l++) begin
                        rem_q[l] <= rem_d[l];
                        dvd_q[l] <= dvd_d[l];
                    end
                    if (iter_cnt_q == LastIter) begin
                        iter_cnt_q <= '0;
                        for (int l = 0; l < int'(NUM_LANES); l++) begin
                            quo_q[elem_idx[l]] <= lane_res[l];
                        end
                        if (pass_cnt_q == LastPass) begin
                            state_q <= StDone;
                        end else begin
                            pass_cnt_q <= pass_cnt_q + PassW'(1);
                            for (int l = 0; l < int'(NUM_LANES); l++) begin
                                rem_q[l] <= '0;
                                dvd_q[l] <= DW'(abs_val(next_num[l])) << FRAC_BITS;
                            end
                        end
                    end else begin
                        iter_cnt_q <= iter_cnt_q + IterW'(1);
                    end
                end
                StDone: begin
                    // First DONE cycle only raises vld_out; the handshake is taken after that.
                    if (!vld_out_q) begin
                        vld_out_q <= 1'b1;
                    end else if (rdy_in) begin
                        vld_out_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        quo_out = '0;
        for (int i = 0; i < int'(VEC_LEN); i++) begin
            quo_out[i*DATA_WIDTH +: DATA_WIDTH] = quo_q[i];
        end
    end

    assign rdy_out      = (state_q == StIdle) && !rst;
    assign vld_out      = vld_out_q;
    assign div_zero_out = div_zero_q;

endmodule
